// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and the baud divider computation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   // Clock cycles per bit, truncated.
   function automatic int calc_scale(input int clk_mhz, input int baud);
      return (clk_mhz * 1000 * 1000) / baud;
   endfunction

endpackage

// File: rtl/multi_push_multi_pop_fifo.sv
// Circular buffer accepting up to NI pushes and NO pops per cycle; the oldest NO
// entries are visible in parallel on o_data, element 0 oldest.
module multi_push_multi_pop_fifo #(
   parameter int W  = 8,
   parameter int D  = 4,
   parameter int NI = 1,
   parameter int NO = 4,
   localparam int CW  = $clog2(D + 1),
   localparam int PIW = $clog2(NI + 1),
   localparam int POW = $clog2(NO + 1),
   localparam int PW  = (D > 1) ? $clog2(D) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PIW-1:0]  i_push,
   input  logic [NI*W-1:0] i_data,
   output logic [CW-1:0]   o_can_push,
   input  logic [POW-1:0]  i_pop,
   output logic [POW-1:0]  o_can_pop,
   output logic [NO*W-1:0] o_data
);

   logic [W-1:0]   r_mem [D];
   logic [PW-1:0]  r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]  r_count;
   logic [POW-1:0] w_pop_eff;
   logic [PIW-1:0] w_push_eff;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
      return PW'((int'(base) + off) % D);
   endfunction

   assign o_can_pop  = (int'(r_count) > NO) ? POW'(NO) : POW'(r_count);
   // Over-sized pop requests are ignored rather than clipped.
   assign w_pop_eff  = (i_pop <= o_can_pop) ? i_pop : '0;
   // Space counts entries freed by this cycle's pop, so a full buffer can
   // accept a push in the same cycle it is popped.
   assign o_can_push = CW'(D - int'(r_count) + int'(w_pop_eff));
   assign w_push_eff = (int'(i_push) <= int'(o_can_push)) ? i_push : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= wrap_add(r_rd_ptr, int'(w_pop_eff));
         r_wr_ptr <= wrap_add(r_wr_ptr, int'(w_push_eff));
         r_count  <= CW'(int'(r_count) + int'(w_push_eff) - int'(w_pop_eff));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst && i < int'(w_push_eff)) begin
            r_mem[wrap_add(r_wr_ptr, i)] <= i_data[i*W +: W];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NO; gi++) begin : g_rd
         assign o_data[gi*W +: W] = r_mem[wrap_add(r_rd_ptr, gi)];
      end
   endgenerate

endmodule

// File: rtl/uart_rx_reader.sv
// Serial line decoder: synchronizes rx, finds start bits, samples mid-bit and
// emits a one-cycle valid (or framing error) at the stop-bit sample.
module uart_rx_reader
   import uart_pkg::*;
#(
   parameter int CLK_MHZ = 50,
   parameter int BAUD    = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_frame_err
);

   localparam int SCALE = calc_scale(CLK_MHZ, BAUD);
   localparam int CW    = (SCALE > 2) ? $clog2(SCALE) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(SCALE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(SCALE - 1);

   logic          r_sync1, r_sync2, r_prev;
   uart_state_t   r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [2:0]    r_idx, w_idx_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          w_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_shift <= w_shift_next;
      end
   end

   assign w_tick = (r_cnt == '0);
   assign o_data = r_shift;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      o_valid      = 1'b0;
      o_frame_err  = 1'b0;
      case (r_state)
         IDLE: begin
            // Falling edge needs a high previous sample, so after a framing
            // error the line must return high before a new frame can start.
            if (r_prev && !r_sync2) begin
               w_cnt_next   = HALF_M1;
               w_state_next = START;
            end
         end
         START: begin
            if (w_tick) begin
               if (!r_sync2) begin
                  w_state_next = DATA;
                  w_cnt_next   = FULL_M1;
                  w_idx_next   = '0;
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_next = {r_sync2, r_shift[7:1]};
               w_cnt_next   = FULL_M1;
               if (r_idx == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_next = IDLE;
               o_valid      = r_sync2;
               o_frame_err  = !r_sync2;
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver: line decoder feeding a multi-pop byte buffer, with sticky
// framing-error and overrun flags.
module uart_rx_module
   import uart_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int N        = 4,
   parameter int clk_mhz  = 50,
   parameter int boadrate = 9600
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   input  logic [$clog2(N+1)-1:0] pop,
   output logic [$clog2(N+1)-1:0] can_pop,
   output logic [N*8-1:0]         data_o,
   input  logic                   clr_err,
   output logic                   frame_err,
   output logic                   overrun
);

   logic                       w_valid;
   logic [7:0]                 w_data;
   logic                       w_ferr;
   logic [$clog2(DEPTH+1)-1:0] w_can_push;
   logic [0:0]                 w_push;
   logic                       w_drop;
   logic                       r_frame_err, r_overrun;

   uart_rx_reader #(
      .CLK_MHZ (clk_mhz),
      .BAUD    (boadrate)
   ) u_reader (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (rx),
      .o_valid     (w_valid),
      .o_data      (w_data),
      .o_frame_err (w_ferr)
   );

   assign w_push = w_valid && (w_can_push != '0);
   assign w_drop = w_valid && (w_can_push == '0);

   multi_push_multi_pop_fifo #(
      .W  (8),
      .D  (DEPTH),
      .NI (1),
      .NO (N)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_data     (w_data),
      .o_can_push (w_can_push),
      .i_pop      (pop),
      .o_can_pop  (can_pop),
      .o_data     (data_o)
   );

   // A new error in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_ferr)       r_frame_err <= 1'b1;
         else if (clr_err) r_frame_err <= 1'b0;
         if (w_drop)       r_overrun <= 1'b1;
         else if (clr_err) r_overrun <= 1'b0;
      end
   end

   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module at 10 clocks per bit; frames are driven
// cycle-exactly so the stop-bit sample lands between edges 97 and 98 of a frame.
module tb_uart_rx_module;
   import uart_pkg::*;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [2:0]  pop;
   logic [2:0]  can_pop;
   logic [31:0] data_o;
   logic        clr_err;
   logic        frame_err;
   logic        overrun;

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_module #(
      .DEPTH    (4),
      .N        (4),
      .clk_mhz  (1),
      .boadrate (100000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .pop       (pop),
      .can_pop   (can_pop),
      .data_o    (data_o),
      .clr_err   (clr_err),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   function automatic logic [7:0] byte_at(input int k);
      return data_o[8*k +: 8];
   endfunction

   task automatic do_reset();
      rx      = 1'b1;
      pop     = '0;
      clr_err = 1'b0;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Returns 1 time unit after the edge that starts the stop bit (edge 90).
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
      @(posedge clk);
      #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (10) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (10) @(posedge clk);
      #1 rx = stop_bit;
      $display("frame 0x%02h stop=%0b", b, stop_bit);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive_frame(b, stop_bit);
      repeat (10) @(posedge clk);
      #1 rx = 1'b1;
   endtask

   initial begin
      rx = 1'b1; pop = '0; clr_err = 1'b0; rst = 1'b1;

      // Reset state
      do_reset();
      check_eq("rst_can_pop", 32'(can_pop), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);

      // Good frame 0xA5, exact latency of the push
      drive_frame(8'hA5, 1'b1);
      repeat (7) @(posedge clk);
      #1 check_eq("a5_before_push", 32'(can_pop), 32'd0);
      @(posedge clk);
      #1 check_eq("a5_can_pop", 32'(can_pop), 32'd1);
      check_eq("a5_data0", 32'(byte_at(0)), 32'hA5);
      check_eq("a5_frame_err", 32'(frame_err), 32'd0);
      check_eq("a5_overrun", 32'(overrun), 32'd0);
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;

      // Glitch: 3-cycle low pulse is rejected
      do_reset();
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      $display("glitch 3 cycles");
      repeat (20) @(posedge clk);
      #1 check_eq("glitch_can_pop", 32'(can_pop), 32'd0);
      check_eq("glitch_state_idle", 32'(dut.u_reader.r_state), 32'(IDLE));
      check_eq("glitch_frame_err", 32'(frame_err), 32'd0);
      send_byte(8'h5A, 1'b1);
      check_eq("post_glitch_can_pop", 32'(can_pop), 32'd1);
      check_eq("post_glitch_data0", 32'(byte_at(0)), 32'h5A);

      // Bad stop bit 0x3C, clr_err collides with the error set
      do_reset();
      drive_frame(8'h3C, 1'b0);
      repeat (7) @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      check_eq("ferr_set_wins", 32'(frame_err), 32'd1);
      check_eq("ferr_can_pop", 32'(can_pop), 32'd0);
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;
      repeat (5) @(posedge clk);
      #1 check_eq("ferr_sticky", 32'(frame_err), 32'd1);
      check_eq("ferr_no_overrun", 32'(overrun), 32'd0);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      check_eq("ferr_cleared", 32'(frame_err), 32'd0);

      // Overrun: five bytes into a four-deep buffer
      do_reset();
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      check_eq("ovr_can_pop", 32'(can_pop), 32'd4);
      check_eq("ovr_data", data_o, 32'h04030201);
      check_eq("ovr_flag", 32'(overrun), 32'd1);
      check_eq("ovr_no_ferr", 32'(frame_err), 32'd0);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      check_eq("ovr_cleared", 32'(overrun), 32'd0);

      // Push into a full buffer in the same cycle as a pop
      drive_frame(8'h06, 1'b1);
      repeat (7) @(posedge clk);
      #1 pop = 3'd1;
      @(posedge clk);
      #1 pop = 3'd0;
      check_eq("pp_can_pop", 32'(can_pop), 32'd4);
      check_eq("pp_data", data_o, 32'h06040302);
      check_eq("pp_no_overrun", 32'(overrun), 32'd0);
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;

      // Pop handling with three bytes buffered (03,04,06)
      pop = 3'd1;
      @(posedge clk);
      #1 pop = 3'd0;
      check_eq("pop1_can_pop", 32'(can_pop), 32'd3);
      check_eq("pop1_data0", 32'(byte_at(0)), 32'h03);
      pop = 3'd4;
      @(posedge clk);
      #1 pop = 3'd0;
      $display("pop 4 (illegal)");
      check_eq("pop4_ignored", 32'(can_pop), 32'd3);
      check_eq("pop4_data0", 32'(byte_at(0)), 32'h03);
      pop = 3'd2;
      @(posedge clk);
      #1 pop = 3'd0;
      $display("pop 2");
      check_eq("pop2_can_pop", 32'(can_pop), 32'd1);
      check_eq("pop2_data0", 32'(byte_at(0)), 32'h06);

      // Reset in the middle of frame 0xFF, then frame 0x12
      do_reset();
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (10) @(posedge clk);
      #1 rx = 1'b1;
      repeat (25) @(posedge clk);
      #1 rst = 1'b1;
      $display("reset mid-frame 0xFF");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (80) @(posedge clk);
      #1 check_eq("abort_can_pop", 32'(can_pop), 32'd0);
      send_byte(8'h12, 1'b1);
      check_eq("abort_rx_can_pop", 32'(can_pop), 32'd1);
      check_eq("abort_rx_data0", 32'(byte_at(0)), 32'h12);
      check_eq("abort_frame_err", 32'(frame_err), 32'd0);
      check_eq("abort_overrun", 32'(overrun), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
